z16_seq_ctrl: RTL and testbench
===============================

Z16_SEQ_CTRL -- requirements
Module: z16_seq_ctrl

Interface
REQ-001 SHALL provide i_clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL provide i_rst, input, 1, synchronous active-high reset.
REQ-003 SHALL provide o_pc, output, 16, current instruction address.
REQ-004 SHALL provide o_imem_req, output, 1, instruction fetch request; i_imem_ack, input, 1, fetch done; i_imem_rdata, input, 16, fetched word.
REQ-005 SHALL provide o_instr, output, 16, latched instruction word, which drives the decoder.
REQ-006 SHALL provide i_opecode, input, 4; i_rd_wen, input, 1; i_mem_wen, input, 1, all decoder outputs for o_instr.
REQ-007 SHALL provide i_br_taken, input, 1, and i_br_target, input, 16, branch decision and target from the execute datapath.
REQ-008 SHALL provide o_dmem_req, output, 1; o_dmem_we, output, 1; i_dmem_ack, input, 1, data-memory handshake.
REQ-009 SHALL provide o_rf_we, output, 1, register-file write strobe.
REQ-010 SHALL provide o_retire, output, 1, one-cycle pulse per completed instruction; o_retire_cnt, output, 16, retired count.
REQ-011 SHALL provide o_state, output, 3, encoding FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; o_halted, output, 1.

Function
REQ-012 FETCH: o_imem_req=1 with o_pc stable; on i_imem_ack, o_instr<=i_imem_rdata and next state is DECODE; no ack means the block stays in FETCH.
REQ-013 DECODE: exactly one cycle, giving combinational decoder settle time; next state is EXEC.
REQ-014 EXEC: exactly one cycle; i_opecode 4'hA or 4'hB goes to MEM; all other opcodes go to WB.
REQ-015 MEM: o_dmem_req=1 and o_dmem_we=i_mem_wen, both held constant until i_dmem_ack; on ack, next state is WB.
REQ-016 WB: o_rf_we=i_rd_wen for one cycle and o_retire=1.
REQ-017 WB PC update: o_pc<=i_br_taken ? i_br_target : o_pc+16'd2; modulo 2^16, so 16'hFFFE wraps to 16'h0000. Next state is FETCH.
REQ-018 o_imem_req, o_dmem_req, o_dmem_we, o_rf_we and o_retire SHALL be registered or state-decoded Moore outputs, zero outside their states.
REQ-019 i_imem_ack outside FETCH and i_dmem_ack outside MEM SHALL be ignored.
REQ-020 An ack arriving in the first cycle of a request SHALL be accepted, giving a minimum FETCH or MEM duration of 1 cycle.
REQ-021 Latency with zero-wait memory: 4 cycles per non-memory instruction and 5 per load/store.
REQ-022 o_retire_cnt SHALL increment on every o_retire and wrap from 16'hFFFF to 16'h0000.
REQ-023 i_br_taken SHALL be sampled only in WB; a branch opcode with i_br_taken=0 falls through.

Reset
REQ-024 On i_rst=1 at a clock edge, the following SHALL hold next cycle: state=FETCH, o_pc=16'h0000, o_instr=16'h0000, o_retire_cnt=0, o_halted=0, o_rf_we=0, o_retire=0, o_dmem_req=0, o_dmem_we=0.
REQ-025 o_imem_req=1 on the first cycle after reset release.
REQ-026 Reset in any state, including mid-handshake, SHALL abandon the transaction without a write strobe or retire pulse.
REQ-027 Reset SHALL override a simultaneous ack.

Configuration
REQ-028 Macro Z16_SEQ_HALT_EN defined: o_instr==16'hFFFF in EXEC goes to HALT with o_retire=1, o_retire_cnt incremented and o_pc unchanged.
REQ-029 HALT SHALL assert o_halted=1 and issue no requests; only i_rst exits it.
REQ-030 Macro Z16_SEQ_HALT_EN undefined: 16'hFFFF executes as an ordinary opcode-F instruction, HALT is unreachable, and o_halted is tied to 0.

Verification
REQ-031 Zero-wait acks, instr 16'h1230 (opcode 0) at pc 0 -> o_rf_we pulse in cycle 4, o_pc=16'h0002, o_retire_cnt=1.
REQ-032 Store 16'h001B with i_dmem_ack delayed 3 cycles -> o_dmem_req and o_dmem_we high 3 cycles, o_rf_we=0 in WB, o_pc=2.
REQ-033 Branch in WB with i_br_taken=1, i_br_target=16'h0040 -> next fetch at o_pc=16'h0040; with i_br_taken=0 -> o_pc+2.
REQ-034 o_pc=16'hFFFE, non-branch instruction -> o_pc wraps to 16'h0000.
REQ-035 i_rst asserted in MEM with i_dmem_ack=1 on the same edge -> state FETCH, o_pc=0, no o_rf_we or o_retire.
REQ-036 Z16_SEQ_HALT_EN defined, fetch 16'hFFFF -> o_halted=1, o_imem_req stays 0 for 20 cycles, o_retire_cnt incremented once.

Source files
------------

// File: rtl/z16_seq_ctrl.sv
// z16_seq_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for a 16-bit core
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   o_pc                         current instruction address
//   o_imem_req/i_imem_ack/i_imem_rdata  instruction fetch handshake
//   o_instr                      latched instruction word for the external decoder
//   i_opecode/i_rd_wen/i_mem_wen decoder outputs for o_instr
//   i_br_taken/i_br_target       branch decision from execute, used only in WB
//   o_dmem_req/o_dmem_we/i_dmem_ack     data memory handshake
//   o_rf_we                      register-file write strobe
//   o_retire/o_retire_cnt        retire pulse and wrapping retire count
//   o_state/o_halted             FSM state (FETCH=0..HALT=5) and halt flag
// Optional: define Z16_SEQ_HALT_EN to make 16'hFFFF a halt instruction.
module z16_seq_ctrl (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [15:0] o_pc,
  output logic        o_imem_req,
  input  logic        i_imem_ack,
  input  logic [15:0] i_imem_rdata,
  output logic [15:0] o_instr,
  input  logic [3:0]  i_opecode,
  input  logic        i_rd_wen,
  input  logic        i_mem_wen,
  input  logic        i_br_taken,
  input  logic [15:0] i_br_target,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  input  logic        i_dmem_ack,
  output logic        o_rf_we,
  output logic        o_retire,
  output logic [15:0] o_retire_cnt,
  output logic [2:0]  o_state,
  output logic        o_halted
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;
  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d, instr_q, instr_d, cnt_q, cnt_d;
  logic        imem_req_q, imem_req_d, dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic        rf_we_q, rf_we_d, retire_q, retire_d, is_halt, is_mem;
`ifdef Z16_SEQ_HALT_EN
  assign is_halt  = instr_q == 16'hFFFF;
  assign o_halted = state_q == HALT;
`else
  assign is_halt  = 1'b0;
  assign o_halted = 1'b0;
`endif
  assign is_mem = i_opecode == 4'hA || i_opecode == 4'hB;
  // Strobes are registered from the next state so they are clean Moore outputs.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      FETCH:  if (i_imem_ack) begin
        instr_d = i_imem_rdata;
        state_d = DECODE;
      end
      DECODE: state_d = EXEC;
      EXEC:   state_d = is_halt ? HALT : is_mem ? MEM : WB;
      MEM:    if (i_dmem_ack) state_d = WB;
      WB: begin
        pc_d    = i_br_taken ? i_br_target : pc_q + 16'd2;
        state_d = FETCH;
      end
      HALT:   state_d = HALT;
      default: state_d = FETCH;
    endcase
    imem_req_d = state_d == FETCH;
    dmem_req_d = state_d == MEM;
    // write-enable is captured on MEM entry and frozen for the whole handshake
    dmem_we_d  = state_d == MEM && (state_q == MEM ? dmem_we_q : i_mem_wen);
    rf_we_d    = state_d == WB && i_rd_wen;
    retire_d   = state_d == WB || (state_d == HALT && state_q == EXEC);
    // count advances at the end of each retire pulse
    cnt_d      = cnt_q + {15'd0, retire_q};
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= FETCH;
      pc_q       <= 16'h0000;
      instr_q    <= 16'h0000;
      cnt_q      <= 16'h0000;
      imem_req_q <= 1'b1;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      retire_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      cnt_q      <= cnt_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      rf_we_q    <= rf_we_d;
      retire_q   <= retire_d;
    end
  end
  assign o_pc         = pc_q;
  assign o_instr      = instr_q;
  assign o_retire_cnt = cnt_q;
  assign o_imem_req   = imem_req_q;
  assign o_dmem_req   = dmem_req_q;
  assign o_dmem_we    = dmem_we_q;
  assign o_rf_we      = rf_we_q;
  assign o_retire     = retire_q;
  assign o_state      = state_q;
endmodule

// File: tb/tb_z16_seq_ctrl.sv
// tb_z16_seq_ctrl: scoreboard bench with randomized memory latencies and branch outcomes
module tb_z16_seq_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0, br_taken = 1'b0;
  logic [15:0] imem_rdata = 16'h0, br_target = 16'h0;
  logic [15:0] o_pc, o_instr, o_retire_cnt;
  logic        o_imem_req, o_dmem_req, o_dmem_we, o_rf_we, o_retire, o_halted;
  logic [2:0]  o_state;
  logic [3:0]  opecode;
  logic        rd_wen, mem_wen;
  always #5 clk = ~clk;
  // decoder contract: opcode in low nibble, rd write unless bit0, store when bit4
  assign opecode = o_instr[3:0];
  assign rd_wen  = ~o_instr[0];
  assign mem_wen = o_instr[4];
  z16_seq_ctrl dut (
    .i_clk(clk), .i_rst(rst), .o_pc(o_pc), .o_imem_req(o_imem_req),
    .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata), .o_instr(o_instr),
    .i_opecode(opecode), .i_rd_wen(rd_wen), .i_mem_wen(mem_wen),
    .i_br_taken(br_taken), .i_br_target(br_target), .o_dmem_req(o_dmem_req),
    .o_dmem_we(o_dmem_we), .i_dmem_ack(dmem_ack), .o_rf_we(o_rf_we),
    .o_retire(o_retire), .o_retire_cnt(o_retire_cnt), .o_state(o_state),
    .o_halted(o_halted)
  );
  typedef struct {
    logic [15:0] instr;
    int          df;
    int          dm;
    bit          taken;
    logic [15:0] target;
  } ent_t;
  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    bit          rf_we;
    bit          we;
    bit          halt;
    int          len;
    int          mcyc;
  } exp_t;
  ent_t        prog[$];
  exp_t        q[$];
  int          vec = 0, errs = 0, n_ret = 0, issue_left = 0;
  logic [15:0] model_pc = 16'h0;
  bit          force_dack = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic bit halt_word(input logic [15:0] i);
`ifdef Z16_SEQ_HALT_EN
    return i == 16'hFFFF;
`else
    return 1'b0;
`endif
  endfunction
  // memory responders and branch-unit stand-in; they also feed the scoreboard
  ent_t cur;
  bit   have = 1'b0, plan_taken = 1'b0;
  int   fw = 0, mw = 0, cur_dm = 0;
  logic [15:0] plan_target = 16'h0;
  always @(negedge clk) begin
    if (rst) begin
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      have = 1'b0;
      fw = 0;
      mw = 0;
    end else begin
      if (o_imem_req && issue_left > 0) begin
        if (!have) begin
          if (prog.size() > 0) cur = prog.pop_front();
          else begin
            cur.instr  = 16'($urandom);
            if ($urandom_range(0, 2) == 0) cur.instr[3:0] = $urandom_range(0, 1) ? 4'hA : 4'hB;
            if (halt_word(cur.instr)) cur.instr = 16'hFFFE;
            cur.df     = $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0;
            cur.dm     = $urandom_range(0, 3);
            cur.taken  = 1'($urandom_range(0, 1));
            cur.target = $urandom_range(0, 7) == 0 ? 16'hFFFE : 16'($urandom);
          end
          have = 1'b1;
          fw = 0;
        end
        if (fw == cur.df) begin
          exp_t e;
          bit   m;
          imem_ack   = 1'b1;
          imem_rdata = cur.instr;
          chk("fetch_pc", o_pc, model_pc);
          chk("fetch_retire_cnt", o_retire_cnt, n_ret);
          e.halt  = halt_word(cur.instr);
          m       = !e.halt && (cur.instr[3:0] == 4'hA || cur.instr[3:0] == 4'hB);
          e.pc    = model_pc;
          e.instr = cur.instr;
          e.rf_we = !e.halt && !cur.instr[0];
          e.we    = m && cur.instr[4];
          e.mcyc  = m ? cur.dm + 1 : 0;
          e.len   = cur.df + 1 + 2 + e.mcyc + 1;
          q.push_back(e);
          model_pc    = e.halt ? model_pc : cur.taken ? cur.target : model_pc + 16'd2;
          cur_dm      = cur.dm;
          plan_taken  = cur.taken;
          plan_target = cur.target;
          issue_left--;
          have = 1'b0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 16'($urandom);
          fw++;
        end
      end else begin
        imem_ack   = o_imem_req ? 1'b0 : 1'($urandom_range(0, 1));
        imem_rdata = 16'($urandom);
      end
      if (o_dmem_req) begin
        if (mw == cur_dm) begin
          dmem_ack = 1'b1;
          mw = 0;
        end else begin
          dmem_ack = 1'b0;
          mw++;
        end
      end else dmem_ack = 1'($urandom_range(0, 1));
      br_taken  = o_state == 3'd4 ? plan_taken : 1'($urandom_range(0, 1));
      br_target = o_state == 3'd4 ? plan_target : 16'($urandom);
    end
    if (force_dack) dmem_ack = 1'b1;
  end
  // monitor: pops the scoreboard on every retire pulse
  int len = 0, mc = 0;
  always @(negedge clk) begin
    if (rst) begin
      len = 0;
      mc = 0;
    end else begin
      len++;
      if (o_dmem_req) begin
        mc++;
        if (q.size() > 0) chk("dmem_we", o_dmem_we, q[0].we);
        else chk("dmem_req_idle", o_dmem_req, 0);
      end
      if (o_retire) begin
        if (q.size() == 0) chk("retire_unexpected", o_retire, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("retire_pc", o_pc, e.pc);
          chk("retire_instr", o_instr, e.instr);
          chk("retire_rf_we", o_rf_we, e.rf_we);
          chk("retire_state", o_state, e.halt ? 3'd5 : 3'd4);
          chk("retire_halted", o_halted, e.halt);
          chk("retire_cnt", o_retire_cnt, n_ret);
          chk("instr_cycles", len, e.len);
          chk("dmem_cycles", mc, e.mcyc);
          n_ret++;
        end
        len = 0;
        mc = 0;
      end else if (o_rf_we) chk("rf_we_outside_wb", o_rf_we, 0);
    end
  end
  task automatic wait_ret(input int goal, input int budget);
    int c = 0;
    while (n_ret < goal && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (n_ret < goal) chk("retire_timeout", n_ret, goal);
    @(negedge clk);
  endtask
  task automatic add(input logic [15:0] i, input int df, input int dm, input bit t, input logic [15:0] tg);
    ent_t e;
    e.instr = i; e.df = df; e.dm = dm; e.taken = t; e.target = tg;
    prog.push_back(e);
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, "_state"}, o_state, 3'd0);
    chk({tag, "_pc"}, o_pc, 16'h0);
    chk({tag, "_instr"}, o_instr, 16'h0);
    chk({tag, "_cnt"}, o_retire_cnt, 16'h0);
    chk({tag, "_halted"}, o_halted, 1'b0);
    chk({tag, "_rf_we"}, o_rf_we, 1'b0);
    chk({tag, "_retire"}, o_retire, 1'b0);
    chk({tag, "_dmem_req"}, o_dmem_req, 1'b0);
    chk({tag, "_dmem_we"}, o_dmem_we, 1'b0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    add(16'h1230, 0, 0, 1'b0, 16'h0000);
    add(16'h001B, 0, 2, 1'b0, 16'h0000);
    add(16'h00A5, 1, 0, 1'b1, 16'h0040);
    add(16'h0007, 0, 0, 1'b0, 16'h1234);
    add(16'h000A, 0, 0, 1'b1, 16'hFFFE);
    add(16'h1230, 2, 0, 1'b0, 16'h0000);
`ifndef Z16_SEQ_HALT_EN
    add(16'hFFFF, 0, 0, 1'b0, 16'h0000);
`endif
    issue_left = prog.size();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("imem_req_after_reset", o_imem_req, 1'b1);
    wait_ret(issue_left + n_ret, 200);
    issue_left = 300;
    wait_ret(n_ret + 300, 12000);
    add(16'h001B, 0, 10, 1'b0, 16'h0000);
    issue_left = 1;
    for (int c = 0; c < 50 && o_state != 3'd3; c++) @(posedge clk);
    chk("reach_mem", o_state, 3'd3);
    @(posedge clk);
    #1 rst = 1'b1;
    force_dack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_state("rst_in_mem");
    force_dack = 1'b0;
    q.delete();
    prog.delete();
    model_pc = 16'h0;
    n_ret = 0;
    issue_left = 20;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_ret(20, 1000);
`ifdef Z16_SEQ_HALT_EN
    add(16'hFFFF, 0, 0, 1'b0, 16'h0000);
    issue_left = 1;
    wait_ret(n_ret + 1, 100);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("halt_imem_req", o_imem_req, 1'b0);
      chk("halt_flag", o_halted, 1'b1);
    end
    chk("halt_cnt", o_retire_cnt, n_ret);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
